mult_datapath: RTL and testbench
================================

MULT_DATAPATH -- requirements
Module: mult_datapath

Interface
REQ-001 SHALL have parameter: WIDTH, 4, operand width in bits (legal 2..16).
REQ-002 SHALL have port: Clk  input  1  rising-edge clock.
REQ-003 SHALL have port: Rst  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: Load  input  1  capture operands, clear accumulator and counter.
REQ-005 SHALL have port: Ad  input  1  add multiplicand into accumulator upper half.
REQ-006 SHALL have port: Sh  input  1  shift accumulator right one bit, advance counter.
REQ-007 SHALL have port: Mcand  input  WIDTH  multiplicand, sampled only on Load.
REQ-008 SHALL have port: Mplier  input  WIDTH  multiplier, sampled only on Load.
REQ-009 SHALL have port: M  output  1  current multiplier LSB (ACC[0]), to control FSM.
REQ-010 SHALL have port: K  output  1  last-shift flag, to control FSM.
REQ-011 SHALL have port: Product  output  2*WIDTH  ACC[2*WIDTH-1:0].
REQ-012 SHALL have port: Err  output  1  protocol error flag (present only under REQ-027).

Function
REQ-013 SHALL hold registers: ACC (2*WIDTH+1 bits, MSB = carry), B (WIDTH bits), CNT (log2 WIDTH bits).
REQ-014 Load SHALL, next edge: ACC <= {0, zeros(WIDTH), Mplier}; B <= Mcand; CNT <= 0.
REQ-015 Ad SHALL, next edge: ACC[2W:W] <= ACC[2W-1:W] + B, carry into ACC[2W]; lower half unchanged.
REQ-016 Sh SHALL, next edge: ACC <= ACC >> 1 (zero into MSB); CNT <= CNT+1, wrapping WIDTH-1 -> 0.
REQ-017 Ad and Sh together SHALL perform add then shift in one cycle: ACC <= ({sum, ACC[W-1:0]}) >> 1; CNT advances.
REQ-018 Load SHALL take priority: Load with Ad and/or Sh behaves as Load alone.
REQ-019 No command asserted SHALL hold all registers.
REQ-020 M SHALL be combinational ACC[0]; updates the cycle after each Load/Sh.
REQ-021 K SHALL be combinational (CNT == WIDTH-1); after Load, K rises after WIDTH-1 shifts, falls after the WIDTH-th.
REQ-022 After Load plus WIDTH shift cycles with Ad asserted exactly when M=1, Product SHALL equal Mcand*Mplier (unsigned).
REQ-023 Latency: one Clk per command; full multiply = 1 Load + WIDTH Sh cycles minimum (combined Ad/Sh) or up to 2*WIDTH.

Reset
REQ-024 Rst low SHALL immediately clear ACC, B, CNT, Err; outputs M=0, K=0 (WIDTH>1), Product=0, Err=0.
REQ-025 Rst low mid-multiply SHALL abort; no partial result retained; Load required to restart.
REQ-026 Commands SHALL be ignored while Rst low; first active edge after release honours commands.

Configuration
REQ-027 Macro MULT_DATAPATH_CHECK_EN defined SHALL add Err: sticky set on Ad while M=0, or on Sh while CNT wraps without an intervening Load; cleared by Load or Rst.
REQ-028 Macro undefined SHALL omit Err port and checking logic; datapath behaviour identical.

Structure
REQ-029 Shared package mult_pkg SHALL hold default WIDTH constant and command-bit encodings shared with Control.
REQ-030 Counter and K decode SHALL be sub-module mult_bit_counter (inputs Clk, Rst, clr, inc; outputs count, last).
REQ-031 Accumulator/adder SHALL stay in mult_datapath; no other sub-modules.

Verification (WIDTH=4)
REQ-032 Reset: Rst=0 mid-operation -> Product=0x00, M=0, K=0, Err=0 immediately, without a clock edge.
REQ-033 Load Mcand=13, Mplier=11 -> next cycle Product=0x0B, M=1, K=0.
REQ-034 13x11 driven as separate Ad then Sh per M -> Product=0x8F (143); K high only before 4th Sh.
REQ-035 15x15 with combined Ad+Sh each cycle -> Product=0xE1 (225), carry bit propagated correctly.
REQ-036 Load asserted together with Ad and Sh -> Load-only result; CNT=0, Product={0x0, Mplier}.
REQ-037 With MULT_DATAPATH_CHECK_EN: Ad while M=0 -> Err=1 next cycle, stays 1 until Load.

Source files
------------

// File: rtl/mult_pkg.sv
// Shared constants for the shift-add multiplier: default operand width and the
// command-bit layout used by both the datapath and its control FSM.
package mult_pkg;

    // Default operand width in bits.
    localparam int unsigned DefaultWidth = 4;

    // Command vector layout {Sh, Ad, Load}, as driven by the control FSM.
    localparam int unsigned CmdBits    = 3;
    localparam int unsigned CmdLoadIdx = 0;
    localparam int unsigned CmdAdIdx   = 1;
    localparam int unsigned CmdShIdx   = 2;

    // Load overrides Ad/Sh, so strip them whenever Load is present.
    function automatic logic [CmdBits-1:0] mult_cmd_resolve(input logic [CmdBits-1:0] cmd);
        logic [CmdBits-1:0] res;
        res = cmd;
        if (cmd[CmdLoadIdx]) begin
            res           = '0;
            res[CmdLoadIdx] = 1'b1;
        end
        return res;
    endfunction

endpackage

// File: rtl/mult_bit_counter.sv
// Shift counter for the multiplier: counts Sh operations modulo WIDTH and flags
// the last one (count == WIDTH-1).
module mult_bit_counter
    import mult_pkg::*;
#(
    parameter int WIDTH = DefaultWidth
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     clr,
    input  logic                     inc,
    output logic [$clog2(WIDTH)-1:0] count,
    output logic                     last
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] count_q;

    // Counter register: clear wins over increment, wrap explicitly for non-power-of-two WIDTH.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            count_q <= '0;
        end else if (clr) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= last ? '0 : count_q + CW'(1);
        end
    end

    assign count = count_q;
    assign last  = (count_q == CW'(WIDTH - 1));

endmodule

// File: rtl/mult_datapath.sv
// Shift-add multiplier datapath: accumulator with carry, multiplicand register and
// shift counter, driven by Load/Ad/Sh from an external control FSM.
// Optional protocol checking (Err output) is enabled by defining MULT_DATAPATH_CHECK_EN.
module mult_datapath
    import mult_pkg::*;
#(
    parameter int WIDTH = DefaultWidth
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Load,
    input  logic               Ad,
    input  logic               Sh,
    input  logic [WIDTH-1:0]   Mcand,
    input  logic [WIDTH-1:0]   Mplier,
    output logic               M,
    output logic               K,
    output logic [2*WIDTH-1:0] Product
`ifdef MULT_DATAPATH_CHECK_EN
    ,
    output logic               Err
`endif
);

    localparam int CW = $clog2(WIDTH);

    logic [CmdBits-1:0] cmd;
    logic               load_en;
    logic               ad_en;
    logic               sh_en;
    logic [2*WIDTH:0]   acc_q;
    logic [2*WIDTH:0]   acc_d;
    logic [2*WIDTH:0]   acc_add;
    logic [WIDTH-1:0]   b_q;
    logic [WIDTH:0]     sum;
    logic [CW-1:0]      cnt;
    logic               last;

    assign cmd[CmdLoadIdx] = Load;
    assign cmd[CmdAdIdx]   = Ad;
    assign cmd[CmdShIdx]   = Sh;

    // Resolve priority once so every register sees the same effective command.
    always_comb begin
        logic [CmdBits-1:0] res;
        res     = mult_cmd_resolve(cmd);
        load_en = res[CmdLoadIdx];
        ad_en   = res[CmdAdIdx];
        sh_en   = res[CmdShIdx];
    end

    // Upper-half adder; the old carry bit is not an operand, it is replaced by the new carry.
    assign sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q};

    // Accumulator next state: optional add, then optional shift in the same cycle.
    always_comb begin
        acc_add = ad_en ? {sum, acc_q[WIDTH-1:0]} : acc_q;
        acc_d   = acc_add;
        if (load_en) begin
            acc_d = {1'b0, {WIDTH{1'b0}}, Mplier};
        end else if (sh_en) begin
            acc_d = {1'b0, acc_add[2*WIDTH:1]};
        end
    end

    // Accumulator and multiplicand registers.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            acc_q <= '0;
            b_q   <= '0;
        end else begin
            acc_q <= acc_d;
            if (load_en) begin
                b_q <= Mcand;
            end
        end
    end

    mult_bit_counter #(
        .WIDTH (WIDTH)
    ) u_counter (
        .Clk   (Clk),
        .Rst   (Rst),
        .clr   (load_en),
        .inc   (sh_en),
        .count (cnt),
        .last  (last)
    );

    assign M       = acc_q[0];
    assign K       = last;
    assign Product = acc_q[2*WIDTH-1:0];

`ifdef MULT_DATAPATH_CHECK_EN
    logic err_q;
    logic wrapped_q;

    // Sticky protocol error: Ad with M=0, or a shift after the counter already wrapped.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            err_q     <= 1'b0;
            wrapped_q <= 1'b0;
        end else if (load_en) begin
            err_q     <= 1'b0;
            wrapped_q <= 1'b0;
        end else begin
            if ((ad_en && !acc_q[0]) || (sh_en && wrapped_q)) begin
                err_q <= 1'b1;
            end
            if (sh_en && (cnt == CW'(WIDTH - 1))) begin
                wrapped_q <= 1'b1;
            end
        end
    end

    assign Err = err_q;
`else
    logic unused_cnt;
    assign unused_cnt = ^cnt;
`endif

endmodule

// File: tb/tb_mult_datapath.sv
// Self-checking bench for mult_datapath (WIDTH=4): directed vector table, hand
// sequences for reset/priority/error corners, and random commands against an
// arithmetic reference model.
module tb_mult_datapath;

    localparam int W = 4;

    logic         Clk = 1'b0;
    logic         Rst = 1'b0;
    logic         Load = 1'b0;
    logic         Ad = 1'b0;
    logic         Sh = 1'b0;
    logic [W-1:0] Mcand = '0;
    logic [W-1:0] Mplier = '0;
    logic         M;
    logic         K;
    logic [2*W-1:0] Product;
`ifdef MULT_DATAPATH_CHECK_EN
    logic         Err;
`endif

    always #5 Clk = ~Clk;

    mult_datapath #(
        .WIDTH (W)
    ) dut (
        .Clk     (Clk),
        .Rst     (Rst),
        .Load    (Load),
        .Ad      (Ad),
        .Sh      (Sh),
        .Mcand   (Mcand),
        .Mplier  (Mplier),
        .M       (M),
        .K       (K),
        .Product (Product)
`ifdef MULT_DATAPATH_CHECK_EN
        ,
        .Err     (Err)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: accumulator as a plain integer, counter as shifts mod W.
    int unsigned m_acc = 0;
    int unsigned m_b = 0;
    int unsigned m_cnt = 0;
    bit          m_err = 1'b0;
    bit          m_wrapped = 1'b0;

    typedef struct {
        int unsigned mcand;
        int unsigned mplier;
        bit          combined;
        int unsigned product;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_acc = 0; m_b = 0; m_cnt = 0; m_err = 1'b0; m_wrapped = 1'b0;
    endtask

    task automatic model_step(input bit l, input bit a, input bit s,
                              input int unsigned mc, input int unsigned mp);
        if (l) begin
            m_acc = mp; m_b = mc; m_cnt = 0; m_err = 1'b0; m_wrapped = 1'b0;
        end else begin
            if (a && (m_acc % 2) == 0) m_err = 1'b1;
            if (s && m_wrapped) m_err = 1'b1;
            if (a) m_acc = (m_acc % (1 << (2 * W))) + (m_b << W);
            if (s) begin
                m_acc = m_acc / 2;
                if (m_cnt == W - 1) m_wrapped = 1'b1;
                m_cnt = (m_cnt + 1) % W;
            end
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".Product"}, 32'(Product), m_acc % (1 << (2 * W)));
        check({tag, ".M"}, 32'(M), m_acc % 2);
        check({tag, ".K"}, 32'(K), 32'(m_cnt == W - 1));
`ifdef MULT_DATAPATH_CHECK_EN
        check({tag, ".Err"}, 32'(Err), 32'(m_err));
`endif
    endtask

    // One clock with the given command; inputs change #1 after the edge.
    task automatic cycle(input bit l, input bit a, input bit s,
                         input int unsigned mc, input int unsigned mp,
                         input string tag, input bit chk);
        Load = l; Ad = a; Sh = s; Mcand = W'(mc); Mplier = W'(mp);
        @(posedge Clk);
        #1;
        model_step(l, a, s, mc % (1 << W), mp % (1 << W));
        Load = 1'b0; Ad = 1'b0; Sh = 1'b0;
        if (chk) compare_all(tag);
    endtask

    // Full multiply driven the way the control FSM would, using the model's M.
    task automatic run_mult(input int unsigned a, input int unsigned b, input bit combined,
                            input int unsigned exp, input string tag);
        cycle(1, 0, 0, a, b, {tag, ".load"}, 1'b1);
        check({tag, ".load_prod"}, 32'(Product), b);
        for (int i = 0; i < W; i++) begin
            bit mk;
            mk = (m_acc % 2) == 1;
            check({tag, ".K_pre"}, 32'(K), 32'(i == W - 1));
            if (combined) begin
                cycle(0, mk, 1, 0, 0, {tag, ".adsh"}, 1'b1);
            end else begin
                if (mk) cycle(0, 1, 0, 0, 0, {tag, ".ad"}, 1'b1);
                cycle(0, 0, 1, 0, 0, {tag, ".sh"}, 1'b1);
            end
        end
        check({tag, ".final"}, 32'(Product), exp);
        check({tag, ".K_end"}, 32'(K), 32'd0);
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{13, 11, 1'b0, 32'h8F};
        vecs[1] = '{15, 15, 1'b1, 32'hE1};
        vecs[2] = '{15, 15, 1'b0, 32'hE1};
        vecs[3] = '{13, 11, 1'b1, 32'h8F};
        vecs[4] = '{0, 9, 1'b1, 32'h00};
        vecs[5] = '{7, 0, 1'b0, 32'h00};
        vecs[6] = '{8, 8, 1'b1, 32'h40};
        vecs[7] = '{9, 6, 1'b0, 32'h36};

        // Reset held from time 0.
        #12;
        check("reset.Product", 32'(Product), 32'h0);
        check("reset.M", 32'(M), 32'h0);
        check("reset.K", 32'(K), 32'h0);
        Rst = 1'b1;
        @(posedge Clk);
        #1;

        // Load 13, 11: Product 0x0B, M=1, K=0.
        cycle(1, 0, 0, 13, 11, "load13x11", 1'b1);
        check("load13x11.P", 32'(Product), 32'h0B);
        check("load13x11.M", 32'(M), 32'h1);
        check("load13x11.K", 32'(K), 32'h0);

        foreach (vecs[i]) begin
            run_mult(vecs[i].mcand, vecs[i].mplier, vecs[i].combined, vecs[i].product,
                     $sformatf("vec%0d", i));
        end

        // Load with Ad and Sh together behaves as Load alone.
        run_mult(5, 3, 1'b1, 15, "pre_prio");
        cycle(0, 1, 0, 0, 0, "pre_prio.ad", 1'b1);
        cycle(1, 1, 1, 6, 10, "prio", 1'b1);
        check("prio.P", 32'(Product), 32'h0A);
        check("prio.K", 32'(K), 32'h0);
        for (int i = 0; i < W - 1; i++) cycle(0, 0, 1, 0, 0, "prio.sh", 1'b1);
        check("prio.K_after3", 32'(K), 32'h1);

        // Idle cycles hold everything.
        cycle(1, 0, 0, 11, 7, "hold.load", 1'b1);
        for (int i = 0; i < 3; i++) cycle(0, 0, 0, 3, 3, "hold", 1'b1);
        check("hold.P", 32'(Product), 32'h07);

        // Asynchronous reset mid-multiply clears outputs without an edge.
        cycle(1, 0, 0, 13, 11, "rst.load", 1'b1);
        cycle(0, 1, 1, 0, 0, "rst.adsh", 1'b1);
        #2;
        Rst = 1'b0;
        #1;
        model_reset();
        check("rst_async.P", 32'(Product), 32'h0);
        check("rst_async.M", 32'(M), 32'h0);
        check("rst_async.K", 32'(K), 32'h0);
`ifdef MULT_DATAPATH_CHECK_EN
        check("rst_async.Err", 32'(Err), 32'h0);
`endif
        // Commands ignored while reset is low.
        Load = 1'b1; Mplier = 4'd5; Mcand = 4'd3;
        @(posedge Clk);
        #1;
        Load = 1'b0;
        check("rst_ignore.P", 32'(Product), 32'h0);
        Rst = 1'b1;
        cycle(1, 0, 0, 3, 5, "rst_release", 1'b1);
        check("rst_release.P", 32'(Product), 32'h05);

`ifdef MULT_DATAPATH_CHECK_EN
        // Ad while M=0 sets Err, which sticks until Load.
        cycle(1, 0, 0, 3, 10, "err.load", 1'b1);
        cycle(0, 1, 0, 0, 0, "err.ad", 1'b1);
        check("err.set", 32'(Err), 32'h1);
        cycle(0, 0, 0, 0, 0, "err.hold", 1'b1);
        cycle(0, 0, 1, 0, 0, "err.hold2", 1'b1);
        check("err.sticky", 32'(Err), 32'h1);
        cycle(1, 0, 0, 3, 10, "err.clear", 1'b1);
        check("err.cleared", 32'(Err), 32'h0);
        // A fifth shift after a full multiply also flags.
        run_mult(3, 5, 1'b1, 15, "err.full");
        check("err.full_ok", 32'(Err), 32'h0);
        cycle(0, 0, 1, 0, 0, "err.overshift", 1'b1);
        check("err.overshift_set", 32'(Err), 32'h1);
`endif

        // Random full multiplies, expected value from plain multiplication.
        for (int i = 0; i < 30; i++) begin
            int unsigned a;
            int unsigned b;
            a = $urandom_range(0, (1 << W) - 1);
            b = $urandom_range(0, (1 << W) - 1);
            run_mult(a, b, 1'($urandom_range(0, 1)), a * b, "rnd_mult");
        end

        // Random command soup against the model.
        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 1)),
                  1'($urandom_range(0, 1)), $urandom_range(0, (1 << W) - 1),
                  $urandom_range(0, (1 << W) - 1), "rnd_cmd", 1'b1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
